// File: rtl/shift_rows.sv
// shift_rows: registered AES ShiftRows/InvShiftRows (clk, reset, in_valid, inv, state in; newstate, out_valid out)
module shift_rows (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             inv,
  input  logic [15:0][7:0] state,
  output logic [15:0][7:0] newstate,
  output logic             out_valid
);
  logic [15:0][7:0] newstate_q, newstate_d, perm;
  logic             out_valid_q;
  for (genvar k = 0; k < 16; k++) begin : g_byte
    localparam int R = k % 4;
    localparam int C = k / 4;
    localparam int F = R + 4 * ((C + R) % 4);
    localparam int I = R + 4 * ((C - R + 4) % 4);
    assign perm[k] = inv ? state[I] : state[F];
  end
  always_comb newstate_d = in_valid ? perm : newstate_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      newstate_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      newstate_q  <= newstate_d;
      out_valid_q <= in_valid;
    end
  end
  assign newstate  = newstate_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_shift_rows.sv
// tb_shift_rows: directed self-checking bench for shift_rows
module tb_shift_rows;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             inv = 1'b0;
  logic [15:0][7:0] state = '0;
  logic [15:0][7:0] newstate;
  logic             out_valid;
  int vectors = 0;
  int miscompares = 0;
  localparam logic [127:0] IDENT   = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] ID_FWD  = 128'h0B06010C07020D08030E09040F0A0500;
  localparam logic [127:0] ID_INV  = 128'h0306090C0F0205080B0E0104070A0D00;
  localparam logic [127:0] MIX     = 128'h0001020304050708090A0080C0E0F0F9;
  localparam logic [127:0] MIX_FWD = 128'h040AF00309E00208C0010780000500F9;

  shift_rows dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .inv(inv),
    .state(state), .newstate(newstate), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic v, input logic i, input logic [127:0] s);
    reset = r; in_valid = v; inv = i; state = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int n = 0; n < 2; n++) begin
      step(1'b1, 1'b1, n[0], 128'hDEADBEEF_01234567_89ABCDEF_55AA33CC);
      vectors++;
      if (newstate !== '0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset[%0d]: got newstate=%h out_valid=%b, want 0/0", n, newstate, out_valid);
      end
    end
  endtask

  task automatic test_identity(input logic i, input logic [127:0] exp);
    step(1'b0, 1'b1, i, IDENT);
    vectors++;
    if (newstate !== exp || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL identity inv=%b: got %h/%b, want %h/1", i, newstate, out_valid, exp);
    end
    step(1'b0, 1'b0, ~i, 128'h0);
    vectors++;
    if (newstate !== exp || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL identity_hold inv=%b: got %h/%b, want %h/0", i, newstate, out_valid, exp);
    end
  endtask

  task automatic test_mixed;
    logic [127:0] fwd;
    step(1'b0, 1'b1, 1'b0, MIX);
    vectors++;
    if (newstate !== MIX_FWD || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mixed_fwd: got %h/%b, want %h/1", newstate, out_valid, MIX_FWD);
    end
    fwd = newstate;
    step(1'b0, 1'b1, 1'b1, fwd);
    vectors++;
    if (newstate !== MIX || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mixed_roundtrip: got %h/%b, want %h/1", newstate, out_valid, MIX);
    end
  endtask

  task automatic test_back_to_back;
    step(1'b0, 1'b1, 1'b0, IDENT);
    vectors++;
    if (newstate !== ID_FWD || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: got %h/%b, want %h/1", newstate, out_valid, ID_FWD);
    end
    step(1'b0, 1'b1, 1'b1, IDENT);
    vectors++;
    if (newstate !== ID_INV || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: got %h/%b, want %h/1", newstate, out_valid, ID_INV);
    end
    for (int n = 0; n < 2; n++) begin
      step(1'b0, 1'b0, 1'b0, MIX);
      vectors++;
      if (newstate !== ID_INV || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_hold[%0d]: got %h/%b, want %h/0", n, newstate, out_valid, ID_INV);
      end
    end
  endtask

  task automatic test_midstream_reset;
    step(1'b0, 1'b1, 1'b0, MIX);
    vectors++;
    if (newstate !== MIX_FWD || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_capture: got %h/%b, want %h/1", newstate, out_valid, MIX_FWD);
    end
    step(1'b1, 1'b1, 1'b1, IDENT);
    vectors++;
    if (newstate !== '0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got %h/%b, want 0/0", newstate, out_valid);
    end
    step(1'b0, 1'b1, 1'b1, IDENT);
    vectors++;
    if (newstate !== ID_INV || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_recover: got %h/%b, want %h/1", newstate, out_valid, ID_INV);
    end
  endtask

  initial begin
    test_reset;
    test_identity(1'b0, ID_FWD);
    test_identity(1'b1, ID_INV);
    test_mixed;
    test_back_to_back;
    test_midstream_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
